fb_scanout_reader: RTL

// - Read side of the frame buffer that line_drawing writes (19-bit FB_addr, 3-bit colour).
// - Generates VGA 640x480 raster timing and issues sequential frame-buffer reads.
// - Outputs pixel colour aligned with hsync, vsync and de.
// - Sits between the FB dual-port RAM read port and the display pins.
// - Exports vblank/frame_start so the drawing controller can schedule buffer work.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/vga_timing_gen.sv | 69 ++++++
 rtl/fb_scanout_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer and VGA 640x480 timing constants, used by the scanout
// reader and by the line-drawing datapath that fills the same buffer.
package fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_ADDR_W  = 19;
  localparam int FB_COLOR_W = 3;

  // One stage of the display-side alignment pipe.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } align_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for one display mode: active window, raw (undelayed) syncs,
// vblank, and the frame boundary markers used by the address counter.
module vga_timing_gen #(
  parameter int   H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int   H_FP     = fb_pkg::H_FP,
  parameter int   H_SYNC   = fb_pkg::H_SYNC,
  parameter int   H_BP     = fb_pkg::H_BP,
  parameter int   V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int   V_FP     = fb_pkg::V_FP,
  parameter int   V_SYNC   = fb_pkg::V_SYNC,
  parameter int   V_BP     = fb_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pix_en,
  output logic o_active,
  output logic o_hsync_raw,
  output logic o_vsync_raw,
  output logic o_vblank,
  output logic o_frame_start,
  output logic o_frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign o_hsync_raw = (r_h_cnt >= HS_BEG && r_h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign o_vsync_raw = (r_v_cnt >= VS_BEG && r_v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign o_vblank    = (r_v_cnt >= V_ACT);
  // Reset is folded in so nothing strobes while the counters are pinned at (0,0).
  assign o_frame_start = i_pix_en & ~i_rst & (r_h_cnt == '0) & (r_v_cnt == '0);
  assign o_frame_end   = w_h_last & w_v_last;

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer read side: walks the buffer sequentially in raster order and
// delays de/syncs by the RAM read latency so colour, syncs and de line up.
module fb_scanout_reader #(
  parameter int   H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int   H_FP     = fb_pkg::H_FP,
  parameter int   H_SYNC   = fb_pkg::H_SYNC,
  parameter int   H_BP     = fb_pkg::H_BP,
  parameter int   V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int   V_FP     = fb_pkg::V_FP,
  parameter int   V_SYNC   = fb_pkg::V_SYNC,
  parameter int   V_BP     = fb_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   RD_LAT   = 1,
  parameter int   ADDR_W   = fb_pkg::FB_ADDR_W,
  parameter int   COLOR_W  = fb_pkg::FB_COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [ADDR_W-1:0]  FB_rd_addr,
  output logic               FB_rd_en,
  input  logic [COLOR_W-1:0] FB_rd_data,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               vblank,
  output logic               frame_start
);

  import fb_pkg::align_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam align_t PIPE_RST = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

  logic w_active;
  logic w_hsync_raw;
  logic w_vsync_raw;
  logic w_frame_end;
  logic w_de_next;

  logic [ADDR_W-1:0]  r_addr_cnt;
  align_t             r_pipe [RD_LAT];
  logic               r_de;
  logic               r_hsync;
  logic               r_vsync;
  logic [COLOR_W-1:0] r_rgb;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pix_en      (pix_en),
    .o_active      (w_active),
    .o_hsync_raw   (w_hsync_raw),
    .o_vsync_raw   (w_vsync_raw),
    .o_vblank      (vblank),
    .o_frame_start (frame_start),
    .o_frame_end   (w_frame_end)
  );

  assign FB_rd_en   = pix_en & ~rst & w_active;
  assign FB_rd_addr = r_addr_cnt;

  // Raster order makes the address a plain counter; wrapping after the last
  // pixel keeps it inside the buffer even through the blanking interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_cnt <= '0;
    end else if (pix_en) begin
      if (w_frame_end) begin
        r_addr_cnt <= '0;
      end else if (w_active) begin
        r_addr_cnt <= (r_addr_cnt == ADDR_LAST) ? '0 : r_addr_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= PIPE_RST;
    end else if (pix_en) begin
      r_pipe[0] <= '{de: w_active, hs: w_hsync_raw, vs: w_vsync_raw};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // The last pipe stage describes the pixel whose data is on FB_rd_data now;
  // registering both together keeps colour and timing on the same edge.
  assign w_de_next = r_pipe[RD_LAT-1].de;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_de    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_rgb   <= '0;
    end else if (pix_en) begin
      r_de    <= w_de_next;
      r_hsync <= r_pipe[RD_LAT-1].hs;
      r_vsync <= r_pipe[RD_LAT-1].vs;
      r_rgb   <= w_de_next ? FB_rd_data : '0;
    end
  end

  assign de      = r_de;
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign rgb_out = r_rgb;

endmodule
